mcs4_clk_gen_prog: RTL



---
 rtl/mcs4_clk_gen_prog_if.sv | 26 ++
 rtl/mcs4_clk_gen_prog.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mcs4_clk_gen_prog_if.sv
// Configuration port of the programmable MCS-4 clock generator: offer/accept
// handshake carrying one complete phase configuration plus a reject pulse.
interface mcs4_clk_gen_prog_if #(
    parameter int unsigned CNT_W = 4
);
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [CNT_W-1:0] cfg_period_i;
    logic [CNT_W-1:0] cfg_p1_start_i;
    logic [CNT_W-1:0] cfg_p1_len_i;
    logic [CNT_W-1:0] cfg_p2_start_i;
    logic [CNT_W-1:0] cfg_p2_len_i;
    logic             cfg_err_o;

    modport master (
        output cfg_valid_i, cfg_period_i, cfg_p1_start_i, cfg_p1_len_i,
               cfg_p2_start_i, cfg_p2_len_i,
        input  cfg_ready_o, cfg_err_o
    );

    modport slave (
        input  cfg_valid_i, cfg_period_i, cfg_p1_start_i, cfg_p1_len_i,
               cfg_p2_start_i, cfg_p2_len_i,
        output cfg_ready_o, cfg_err_o
    );
endinterface

// File: rtl/mcs4_clk_gen_prog.sv
// Programmable two-phase non-overlapping PHI1/PHI2 generator with run/stop,
// 8-subcycle SYNC marker and a one-deep config slot applied at cycle boundaries.
module mcs4_clk_gen_prog #(
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PERIOD   = 7,
    parameter int unsigned P1_START = 0,
    parameter int unsigned P1_LEN   = 2,
    parameter int unsigned P2_START = 4,
    parameter int unsigned P2_LEN   = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                en_i,
    mcs4_clk_gen_prog_if.slave  cfg,
    output logic                PHI1_o,
    output logic                PHI2_o,
    output logic                SYNC_o,
    output logic [2:0]          subcycle_o,
    output logic                running_o
);

    typedef enum logic {IDLE, RUN} state_e;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] p1_start;
        logic [CNT_W-1:0] p1_len;
        logic [CNT_W-1:0] p2_start;
        logic [CNT_W-1:0] p2_len;
    } phase_cfg_t;

    localparam phase_cfg_t RESET_CFG = '{
        period:   CNT_W'(PERIOD),
        p1_start: CNT_W'(P1_START),
        p1_len:   CNT_W'(P1_LEN),
        p2_start: CNT_W'(P2_START),
        p2_len:   CNT_W'(P2_LEN)
    };

    // Window ends are formed one bit wider so start+len cannot wrap around.
    function automatic logic cfg_legal(input phase_cfg_t c);
        logic [CNT_W:0] end1;
        logic [CNT_W:0] end2;
        end1 = {1'b0, c.p1_start} + {1'b0, c.p1_len};
        end2 = {1'b0, c.p2_start} + {1'b0, c.p2_len};
        return (c.period >= CNT_W'(2))
            && (c.p1_len != '0) && (c.p2_len != '0)
            && (end1 <= {1'b0, c.period}) && (end2 <= {1'b0, c.period})
            && ((end1 <= {1'b0, c.p2_start}) || (end2 <= {1'b0, c.p1_start}));
    endfunction

    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] start,
                                       input logic [CNT_W-1:0] len);
        return ({1'b0, cnt} >= {1'b0, start})
            && ({1'b0, cnt} <  ({1'b0, start} + {1'b0, len}));
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       sub_q;
    phase_cfg_t       act_q;
    phase_cfg_t       pend_q;
    logic             pend_vld_q;
    logic             err_q;
    logic             phi1_q;
    logic             phi2_q;
    logic             sync_q;

    phase_cfg_t offer;
    logic       offer_legal;
    logic       accept;
    logic       wrap;
    logic       apply;
    logic       phi1_d;
    logic       phi2_d;
    logic       sync_d;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        offer = '{
            period:   cfg.cfg_period_i,
            p1_start: cfg.cfg_p1_start_i,
            p1_len:   cfg.cfg_p1_len_i,
            p2_start: cfg.cfg_p2_start_i,
            p2_len:   cfg.cfg_p2_len_i
        };
        offer_legal = cfg_legal(offer);
        accept      = cfg.cfg_valid_i && !pend_vld_q;
        wrap        = (state_q == RUN) && (cnt_q == act_q.period - 1'b1);
        apply       = pend_vld_q && ((state_q == IDLE) || wrap);
        phi1_d      = !((state_q == RUN) && in_window(cnt_q, act_q.p1_start, act_q.p1_len));
        phi2_d      = !((state_q == RUN) && in_window(cnt_q, act_q.p2_start, act_q.p2_len));
        sync_d      = !((state_q == RUN) && (sub_q == 3'd7));
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sub_q      <= '0;
            act_q      <= RESET_CFG;
            pend_q     <= RESET_CFG;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
            phi1_q     <= 1'b1;
            phi2_q     <= 1'b1;
            sync_q     <= 1'b1;
        end else begin
            phi1_q <= phi1_d;
            phi2_q <= phi2_d;
            sync_q <= sync_d;
            err_q  <= accept && !offer_legal;

            // accept needs an empty slot and apply a full one, so they never coincide.
            if (accept && offer_legal) begin
                pend_q     <= offer;
                pend_vld_q <= 1'b1;
            end else if (apply) begin
                pend_vld_q <= 1'b0;
            end

            if (apply) begin
                act_q <= pend_q;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (en_i) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        sub_q <= sub_q + 3'd1;
                        if (!en_i) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PHI1_o          = phi1_q;
    assign PHI2_o          = phi2_q;
    assign SYNC_o          = sync_q;
    assign subcycle_o      = sub_q;
    assign running_o       = (state_q == RUN);
    assign cfg.cfg_ready_o = !pend_vld_q;
    assign cfg.cfg_err_o   = err_q;

endmodule
